// File: rtl/order_budget_gate.sv
// order_budget_gate: checks each order quantity against a running 4-bit budget,
// debits the budget on accept, and reports the decision on a valid/ready channel.
// A run of consecutive rejects locks the gate until it is explicitly released.
module order_budget_gate #(
    parameter int unsigned REJECT_LOCK = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_load,
    input  logic [3:0] cfg_budget,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_qty,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_accept,
    output logic [3:0] out_remaining,
    output logic       locked,
    input  logic       unlock
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RESP   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // Lockout threshold narrowed to the reject counter width.
    localparam logic [3:0] LOCK_TH = 4'(REJECT_LOCK);

    state_t     state_q, state_d;
    logic [3:0] budget_q, budget_d;
    logic [3:0] qty_q, qty_d;
    logic [3:0] rej_cnt_q, rej_cnt_d;
    logic       out_accept_q, out_accept_d;
    logic [3:0] out_remaining_q, out_remaining_d;

    logic [4:0] sub_res;
    logic [3:0] diff;
    logic       borrow;
    logic       accept;

    // Unsigned subtraction with the borrow returned in the top bit.
    function automatic logic [4:0] sub_borrow(input logic [3:0] a, input logic [3:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Reject counter increment that saturates at its maximum instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Budget check: an order is accepted only if it is non-zero and fits the budget.
    always_comb begin
        sub_res = sub_borrow(budget_q, qty_q);
        diff    = sub_res[3:0];
        borrow  = sub_res[4];
        accept  = !borrow && (qty_q != 4'd0);
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        in_ready      = (state_q == IDLE) && !cfg_load && !rst;
        out_valid     = (state_q == RESP);
        locked        = (state_q == LOCKED);
        out_accept    = out_accept_q;
        out_remaining = out_remaining_q;
    end

    // Next-state and register-update logic for the order FSM.
    always_comb begin
        state_d         = state_q;
        budget_d        = budget_q;
        qty_d           = qty_q;
        rej_cnt_d       = rej_cnt_q;
        out_accept_d    = out_accept_q;
        out_remaining_d = out_remaining_q;

        case (state_q)
            IDLE: begin
                // A configuration load wins over an order offered in the same cycle.
                if (cfg_load) begin
                    budget_d = cfg_budget;
                end else if (in_valid) begin
                    qty_d   = in_qty;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    budget_d        = diff;
                    rej_cnt_d       = 4'd0;
                    out_accept_d    = 1'b1;
                    out_remaining_d = diff;
                end else begin
                    rej_cnt_d       = sat_inc(rej_cnt_q);
                    out_accept_d    = 1'b0;
                    out_remaining_d = budget_q;
                end
                state_d = RESP;
            end
            RESP: begin
                // Decision is held until the consumer takes it.
                if (out_ready) begin
                    state_d = (rej_cnt_q >= LOCK_TH) ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // Budget may be reprogrammed while locked; unlock releases independently.
                if (cfg_load) begin
                    budget_d = cfg_budget;
                end
                if (unlock) begin
                    rej_cnt_d = 4'd0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            budget_q        <= 4'd0;
            qty_q           <= 4'd0;
            rej_cnt_q       <= 4'd0;
            out_accept_q    <= 1'b0;
            out_remaining_q <= 4'd0;
        end else begin
            state_q         <= state_d;
            budget_q        <= budget_d;
            qty_q           <= qty_d;
            rej_cnt_q       <= rej_cnt_d;
            out_accept_q    <= out_accept_d;
            out_remaining_q <= out_remaining_d;
        end
    end

endmodule

// File: doc/order_budget_gate.md
# order_budget_gate

Sequential risk gate that sits directly downstream of the 4-bit borrow/difference arithmetic in the risk-check path. It accepts one order quantity at a time and compares it against a running 4-bit budget (budget − qty, with unsigned borrow). Accepted orders debit the budget. Each accept/reject result goes out on a valid/ready channel. After a configurable number of consecutive rejects, the gate locks until it is explicitly released.

## Interface
- `REJECT_LOCK`, default 3: consecutive rejects that trigger lockout. Legal range 1..15.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_load`, in, 1: load `cfg_budget` into the budget register.
- `cfg_budget`, in, 4: new budget value (unsigned).
- `in_valid`, in, 1: order quantity valid.
- `in_ready`, out, 1: gate can take an order.
- `in_qty`, in, 4: order quantity (unsigned).
- `out_valid`, out, 1: decision valid.
- `out_ready`, in, 1: consumer takes the decision.
- `out_accept`, out, 1: 1 = order accepted, 0 = order rejected.
- `out_remaining`, out, 4: budget after this decision.
- `locked`, out, 1: gate is in lockout.
- `unlock`, in, 1: release lockout (sampled only in LOCKED).

## Operation
- **Registers:**
  - `budget[3:0]`
  - `qty_r[3:0]`
  - `rej_cnt[3:0]`
  - state ∈ {IDLE, CHECK, RESP, LOCKED}
  - output registers `out_accept` and `out_remaining`
- **Reset (`rst`=1):**
  - state = IDLE; `budget`, `qty_r`, `rej_cnt` = 0.
  - `out_valid`, `out_accept`, `out_remaining`, `locked` = 0.
  - `in_ready` = 0 while `rst` is high.
  - Reset in any state drops any pending order; no response is issued for it.
- **`in_ready`** = (state == IDLE) && !`cfg_load` && !`rst`. The input handshake is `in_valid` && `in_ready`.
- **IDLE:**
  - `cfg_load` → `budget` ← `cfg_budget`. It takes priority over a simultaneous `in_valid`, whose order is not taken that cycle.
  - Input handshake → `qty_r` ← `in_qty`, go to CHECK.
- **CHECK** (exactly 1 cycle):
  - diff = `budget` − `qty_r` (mod 16); borrow = (`qty_r` > `budget`).
  - Accept iff !borrow && `qty_r` ≠ 0.
  - Accept: `budget` ← diff, `rej_cnt` ← 0, `out_accept` ← 1.
  - Reject: `budget` unchanged, `rej_cnt` ← min(`rej_cnt`+1, 15), `out_accept` ← 0.
  - `out_remaining` ← budget value after the update. Go to RESP.
  - `cfg_load` is ignored in this state.
- **RESP:**
  - `out_valid` = 1. `out_accept` and `out_remaining` are held stable until `out_ready`.
  - `cfg_load` is ignored in this state.
  - On `out_ready`: if `rej_cnt` ≥ `REJECT_LOCK`, go to LOCKED; otherwise go to IDLE. `out_valid` drops in the following cycle.
- **LOCKED:**
  - `locked` = 1, `in_ready` = 0.
  - `cfg_load` still updates `budget`; the state stays LOCKED.
  - `unlock` → `rej_cnt` ← 0, `locked` ← 0, go to IDLE.
  - `cfg_load` and `unlock` in the same cycle: both take effect.
- The budget never underflows and never wraps; it is only debited on accept.

## Timing
- Input handshake at edge N → CHECK during cycle N+1 → `out_valid` high from cycle N+2.
- Minimum spacing is 3 cycles per order (IDLE, CHECK, RESP), plus any backpressure.
- `out_valid` deasserts on the cycle after the `out_ready` handshake.
- `in_ready` reasserts in the same cycle, if no lockout and no `cfg_load`.
- `locked` asserts the cycle after the RESP handshake that triggers lockout.
- `locked` deasserts the cycle after `unlock` is sampled.
- The budget written by `cfg_load` is visible to an order accepted in the following cycle.

## Test plan
1. **Basic accept:** reset, `cfg_load` 10, order 3 → `out_valid` 2 cycles after the input handshake, `out_accept`=1, `out_remaining`=7.
2. **Over-budget reject:** with budget 7, order 8 → `out_accept`=0, `out_remaining`=7. Order 0 → reject, remaining 7.
3. **Exact-budget boundary:** budget 5, order 5 → accept, remaining 0. Then order 1 → reject, remaining 0.
4. **Lockout** (`REJECT_LOCK`=3):
   - Three consecutive rejects → `locked`=1 after the third RESP handshake; `in_ready`=0 while `in_valid`=1.
   - `unlock` → IDLE; the next over-budget reject does not lock (`rej_cnt` was cleared).
   - An accept between rejects resets the count.
5. **Backpressure:**
   - Hold `out_ready` low 4 cycles in RESP → outputs stable and `in_ready`=0 throughout.
   - `cfg_load` 15 during RESP is ignored; budget is unchanged after the handshake.
6. **Simultaneous events:**
   - `cfg_load` 9 with `in_valid` (qty 9) in IDLE → `in_ready`=0 that cycle. The order is taken next cycle → accept, remaining 0.
   - `rst` asserted during CHECK → no `out_valid`, all outputs 0, budget 0.
